// File: rtl/req_arb_pkg.sv
// Shared definitions for the round-robin request arbiter.
// Holds default sizes and the rotating-priority pick helper.
package req_arb_pkg;

  localparam int NREQ_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // First set bit of elig at or above ptr, wrapping at n (n <= 32).
  function automatic pick_t rr_pick(
    input logic [31:0] elig,
    input int unsigned ptr,
    input int unsigned n
  );
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && elig[j[4:0]]) begin
        r.found = 1'b1;
        r.idx   = j[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/req_arb_rr_slot.sv
// One-entry holding slot for a single requester.
// A slot drained this cycle may be refilled in the same cycle.
module req_slot
  import req_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic             grant,
  output logic             rdy,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  logic accept;

  assign rdy    = !full | grant;
  assign accept = ena & rdy;

  // Refill wins over the drain clear.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) dout <= din;
  end

endmodule

// File: rtl/req_arb_rr.sv
// Round-robin arbiter sharing one callee among NREQ requesters.
// Pointer, grant mask, winner mux and output drive live here.
module req_arb_rr
  import req_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_a__ENA,
  input  logic [NREQ*WIDTH-1:0] req_a_v,
  output logic [NREQ-1:0]       req_a__RDY,
  input  logic                  setMask__ENA,
  input  logic [NREQ-1:0]       setMask_v,
  output logic                  setMask__RDY,
  output logic                  out_a__ENA,
  output logic [WIDTH-1:0]      out_a_v,
  input  logic                  out_a__RDY
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [NREQ-1:0]  mask;
  logic [NREQ-1:0]  slot_v;
  logic [WIDTH-1:0] slot_d [NREQ];
  logic [NREQ-1:0]  grant;
  logic [31:0]      elig_w;
  pick_t            pick;
  logic [PW-1:0]    winner;

  assign setMask__RDY = 1'b1;

  always_comb begin
    elig_w           = '0;
    elig_w[NREQ-1:0] = slot_v & mask;
    pick   = rr_pick(elig_w, 32'(ptr), NREQ);
    winner = pick.idx[PW-1:0];
  end

  assign out_a__ENA = out_a__RDY & pick.found;
  assign out_a_v    = slot_d[winner];

  always_comb begin
    grant = '0;
    if (out_a__ENA) grant[winner] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ptr <= '0;
    end else if (out_a__ENA) begin
      if (winner == PW'(NREQ - 1)) ptr <= '0;
      else ptr <= winner + 1'b1;
    end
  end

  // A mask written this cycle only affects the next grant.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mask <= '1;
    end else if (setMask__ENA) begin
      mask <= setMask_v;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    req_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .CLK  (CLK),
      .nRST (nRST),
      .ena  (req_a__ENA[i]),
      .din  (req_a_v[i*WIDTH +: WIDTH]),
      .grant(grant[i]),
      .rdy  (req_a__RDY[i]),
      .full (slot_v[i]),
      .dout (slot_d[i])
    );
  end

endmodule

// File: tb/tb_req_arb_rr.sv
// Randomized bench for req_arb_rr against a behavioural model,
// plus directed scenarios pinned with literal expectations.
module tb_req_arb_rr;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_ena;
  logic [N*W-1:0] req_v;
  logic [N-1:0]   req_rdy;
  logic           mask_ena;
  logic [N-1:0]   mask_v;
  logic           mask_rdy;
  logic           out_ena;
  logic [W-1:0]   out_v;
  logic           out_rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_arb_rr #(.NREQ(N), .WIDTH(W)) dut (
    .CLK         (clk),
    .nRST        (rst_n),
    .req_a__ENA  (req_ena),
    .req_a_v     (req_v),
    .req_a__RDY  (req_rdy),
    .setMask__ENA(mask_ena),
    .setMask_v   (mask_v),
    .setMask__RDY(mask_rdy),
    .out_a__ENA  (out_ena),
    .out_a_v     (out_v),
    .out_a__RDY  (out_rdy)
  );

  // Model state: what the arbiter holds after the last edge.
  bit           mv [N] = '{default: 1'b0};
  logic [W-1:0] md [N];
  int           mptr  = 0;
  logic [N-1:0] mmask = '1;

  bit           e_ena;
  logic [W-1:0] e_v;
  int           e_win;
  logic [N-1:0] e_rdy;

  task automatic eval_model();
    e_win = -1;
    e_v   = '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (e_win < 0 && mv[i] && mmask[i]) e_win = i;
    end
    e_ena = out_rdy && (e_win >= 0);
    if (e_ena) e_v = md[e_win];
    for (int i = 0; i < N; i++)
      e_rdy[i] = !mv[i] || (e_ena && e_win == i);
  endtask

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    eval_model();
    check("out_ena", 64'(out_ena), 64'(e_ena));
    if (e_ena) check("out_v", 64'(out_v), 64'(e_v));
    check("req_rdy", 64'(req_rdy), 64'(e_rdy));
    check("mask_rdy", 64'(mask_rdy), 64'd1);
    if (rst_n) begin
      for (int i = 0; i < N; i++)
        assert (!(req_ena[i] && !req_rdy[i]))
          else $error("protocol violation on req %0d", i);
    end
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
      mptr  = 0;
      mmask = '1;
    end else begin
      if (e_ena) begin
        mv[e_win] = 1'b0;
        mptr = (e_win + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (req_ena[i] && e_rdy[i]) begin
          mv[i] = 1'b1;
          md[i] = req_v[i*W +: W];
        end
      end
      if (mask_ena) mmask = mask_v;
    end
  end

  // Payload for requester i is {tag, i} so the low byte names it.
  task automatic drive(logic rn, logic [N-1:0] ena, logic orr,
                       logic me, logic [N-1:0] mval, int tag);
    rst_n    = rn;
    out_rdy  = orr;
    mask_ena = me;
    mask_v   = mval;
    for (int i = 0; i < N; i++)
      req_v[i*W +: W] = {tag[23:0], 8'(i)};
    eval_model();
    req_ena = rn ? (ena & e_rdy) : ena;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, '0, 1, 0, '1, 0);
    tick();
    tick();

    drive(1, '0, 1, 0, '1, 0);
    check("rst_out_ena", 64'(out_ena), 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'hF);
    check("rst_ptr", 64'(dut.ptr), 64'd0);
    tick();

    drive(1, 4'b0100, 1, 0, '1, 0);
    req_v[2*W +: W] = 32'h55;
    tick();
    drive(1, '0, 1, 0, '1, 1);
    check("first_ena", 64'(out_ena), 64'd1);
    check("first_v", 64'(out_v), 64'h55);
    tick();
    check("model_ptr", 64'(mptr), 64'd3);
    check("first_ptr", 64'(dut.ptr), 64'd3);

    drive(0, '0, 1, 0, '1, 0);
    tick();
    drive(1, '1, 0, 0, '1, 2);
    tick();
    for (int c = 0; c < 8; c++) begin
      drive(1, '1, 1, 0, '1, 16 + c);
      check("fair_win", 64'(out_v[7:0]), 64'(c % 4));
      check("fair_rdy", 64'(req_rdy), 64'(1 << (c % 4)));
      tick();
    end

    for (int c = 0; c < 5; c++) begin
      drive(1, '1, 0, 0, '1, 32 + c);
      check("stall_ena", 64'(out_ena), 64'd0);
      check("stall_rdy", 64'(req_rdy), 64'd0);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1, '1, 1, 0, '1, 40 + c);
      check("resume_win", 64'(out_v[7:0]), 64'(c));
      tick();
    end

    drive(1, '0, 0, 1, 4'b1010, 48);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1, 4'b1010, 1, 0, '1, 50 + c);
      check("mask_win", 64'(out_v[7:0]),
            64'((c % 2 == 1) ? 3 : 1));
      tick();
    end
    drive(1, '0, 0, 1, 4'b1111, 56);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1, '0, 1, 0, '1, 60 + c);
      check("unmask_win", 64'(out_v[7:0]), 64'(c));
      tick();
    end

    drive(1, '1, 0, 0, '1, 70);
    tick();
    drive(1, '0, 0, 1, 4'b0000, 71);
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1, '1, 1, 0, '1, 72 + c);
      check("zmask_ena", 64'(out_ena), 64'd0);
      check("zmask_rdy", 64'(req_rdy), 64'd0);
      tick();
    end
    drive(1, '0, 0, 1, 4'b1111, 80);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1, '0, 1, 0, '1, 81 + c);
      check("zmask_drain", 64'(out_ena), 64'd1);
      tick();
    end

    drive(1, 4'b1010, 0, 1, 4'b0101, 90);
    tick();
    drive(0, '0, 1, 0, '1, 91);
    tick();
    drive(1, '0, 1, 0, '1, 92);
    check("mrst_ena", 64'(out_ena), 64'd0);
    check("mrst_rdy", 64'(req_rdy), 64'hF);
    check("mrst_ptr", 64'(dut.ptr), 64'd0);
    check("mrst_mask", 64'(dut.mask), 64'hF);
    tick();

    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] mval;
      mval = ($urandom_range(0, 2) == 0) ?
             N'($urandom) : '1;
      drive(($urandom_range(0, 199) != 0),
            N'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            mval,
            int'($urandom));
      tick();
    end

    drive(1, '0, 1, 0, '1, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
